// File: rtl/pu_or1k_pkg.sv
// Shared types for the OR1K store-drain path: drain FSM states and store-buffer entry sizing.
package pu_or1k_pkg;

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_POP,
    DRAIN_WB_STORE,
    DRAIN_WB_LOAD
  } drain_state_e;

  // Entry layout is {adr, dat, bsel, pc, atomic}.
  function automatic int sb_entry_width(input int w);
    return 3 * w + w / 8 + 1;
  endfunction

endpackage

// File: rtl/pu_or1k_store_buffer.sv
// Store buffer FIFO: same-cycle write and read allowed, read data registered (valid the cycle after rd_en).
module pu_or1k_store_buffer
  import pu_or1k_pkg::*;
#(
  parameter int DEPTH_WIDTH          = 4,
  parameter int OPTION_OPERAND_WIDTH = 32,
  localparam int ENTRY_W             = sb_entry_width(OPTION_OPERAND_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               empty,
  output logic               full
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [DEPTH_WIDTH:0] wr_ptr;
  logic [DEPTH_WIDTH:0] rd_ptr;
  logic                 do_wr;
  logic                 do_rd;

  // Extra pointer bit tells a full buffer apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_WIDTH] != rd_ptr[DEPTH_WIDTH]) &&
                 (wr_ptr[DEPTH_WIDTH-1:0] == rd_ptr[DEPTH_WIDTH-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (DEPTH_WIDTH+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (DEPTH_WIDTH+1)'(1);
    end
  end

  // NOTE: storage and read register are not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[DEPTH_WIDTH-1:0]] <= wr_data;
    if (do_rd) rd_data <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
  end

endmodule

// File: rtl/pu_or1k_store_drain_ctrl.sv
// Buffers LSU stores and drains them in order onto a Wishbone master; loads wait for the buffer to empty.
module pu_or1k_store_drain_ctrl
  import pu_or1k_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int DEPTH_WIDTH          = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              st_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   st_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   st_dat_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   st_pc_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] st_bsel_i,
  input  logic                              st_atomic_i,
  output logic                              st_ack_o,
  input  logic                              ld_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   ld_adr_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] ld_bsel_i,
  output logic                              ld_ack_o,
  output logic                              ld_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   ld_dat_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   wbm_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   wbm_dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] wbm_sel_o,
  output logic                              wbm_we_o,
  output logic                              wbm_cyc_o,
  output logic                              wbm_stb_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   wbm_dat_i,
  input  logic                              wbm_ack_i,
  input  logic                              wbm_err_i,
  output logic                              store_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_pc_o,
  output logic                              atomic_done_o,
  output logic                              idle_o
);

  localparam int W       = OPTION_OPERAND_WIDTH;
  localparam int SEL_W   = W / 8;
  localparam int ENTRY_W = sb_entry_width(W);

  drain_state_e         state;
  drain_state_e         state_nxt;
  logic                 buf_rd;
  logic                 buf_empty;
  logic                 buf_full;
  logic [ENTRY_W-1:0]   buf_wdata;
  logic [ENTRY_W-1:0]   buf_rdata;
  logic [W-1:0]         head_adr;
  logic [W-1:0]         head_dat;
  logic [W-1:0]         head_pc;
  logic [SEL_W-1:0]     head_sel;
  logic                 head_atomic;
  logic [W-1:0]         cur_pc;
  logic                 cur_atomic;
  logic                 atomic_pending;
  logic                 bus_done;
  logic                 store_err_hit;
  logic                 cyc_q;

  assign st_ack_o  = st_req_i && !buf_full && !atomic_pending;
  assign buf_wdata = {st_adr_i, st_dat_i, st_bsel_i, st_pc_i, st_atomic_i};
  assign {head_adr, head_dat, head_sel, head_pc, head_atomic} = buf_rdata;
  assign bus_done  = wbm_ack_i || wbm_err_i;
  assign ld_dat_o  = wbm_dat_i;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;

  pu_or1k_store_buffer #(
    .DEPTH_WIDTH         (DEPTH_WIDTH),
    .OPTION_OPERAND_WIDTH(OPTION_OPERAND_WIDTH)
  ) u_store_buffer (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (st_ack_o),
    .wr_data(buf_wdata),
    .rd_en  (buf_rd),
    .rd_data(buf_rdata),
    .empty  (buf_empty),
    .full   (buf_full)
  );

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= DRAIN_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      DRAIN_IDLE: begin
        if (!buf_empty)                 state_nxt = DRAIN_POP;
        else if (ld_req_i && !st_ack_o) state_nxt = DRAIN_WB_LOAD;
      end
      DRAIN_POP:      state_nxt = DRAIN_WB_STORE;
      DRAIN_WB_STORE: if (bus_done) state_nxt = DRAIN_IDLE;
      DRAIN_WB_LOAD:  if (bus_done) state_nxt = DRAIN_IDLE;
      default:        state_nxt = DRAIN_IDLE;
    endcase
  end

  always_comb begin
    buf_rd        = (state == DRAIN_IDLE) && !buf_empty;
    ld_ack_o      = (state == DRAIN_WB_LOAD) && wbm_ack_i;
    ld_err_o      = (state == DRAIN_WB_LOAD) && wbm_err_i && !wbm_ack_i;
    store_err_hit = (state == DRAIN_WB_STORE) && wbm_err_i && !wbm_ack_i;
    atomic_done_o = (state == DRAIN_WB_STORE) && wbm_ack_i && cur_atomic;
    idle_o        = (state == DRAIN_IDLE) && buf_empty && !st_ack_o;
  end

  // Bus control, atomic tracking and error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q          <= 1'b0;
      wbm_we_o       <= 1'b0;
      cur_atomic     <= 1'b0;
      atomic_pending <= 1'b0;
      store_err_o    <= 1'b0;
      store_err_pc_o <= '0;
    end else begin
      store_err_o <= store_err_hit;
      if (store_err_hit) store_err_pc_o <= cur_pc;
      if ((state == DRAIN_WB_STORE) && bus_done && cur_atomic) atomic_pending <= 1'b0;
      if (st_ack_o && st_atomic_i) atomic_pending <= 1'b1;
      case (state)
        DRAIN_IDLE: if (state_nxt == DRAIN_WB_LOAD) begin
          cyc_q    <= 1'b1;
          wbm_we_o <= 1'b0;
        end
        DRAIN_POP: begin
          cyc_q      <= 1'b1;
          wbm_we_o   <= 1'b1;
          cur_atomic <= head_atomic;
        end
        default: if (bus_done) begin
          cyc_q    <= 1'b0;
          wbm_we_o <= 1'b0;
        end
      endcase
    end
  end

  // Bus address/data are qualified by cyc, so they carry no reset.
  always_ff @(posedge clk) begin
    if ((state == DRAIN_IDLE) && (state_nxt == DRAIN_WB_LOAD)) begin
      wbm_adr_o <= ld_adr_i;
      wbm_sel_o <= ld_bsel_i;
    end else if (state == DRAIN_POP) begin
      wbm_adr_o <= head_adr;
      wbm_dat_o <= head_dat;
      wbm_sel_o <= head_sel;
      cur_pc    <= head_pc;
    end
  end

endmodule

// File: tb/tb_pu_or1k_store_drain_ctrl.sv
// Directed bench for the store-drain controller with a small Wishbone slave model that logs every bus cycle.
module tb_pu_or1k_store_drain_ctrl;

  localparam int W  = 32;
  localparam int DW = 2;

  logic          clk;
  logic          rst;
  logic          st_req_i;
  logic [W-1:0]  st_adr_i;
  logic [W-1:0]  st_dat_i;
  logic [W-1:0]  st_pc_i;
  logic [3:0]    st_bsel_i;
  logic          st_atomic_i;
  logic          st_ack_o;
  logic          ld_req_i;
  logic [W-1:0]  ld_adr_i;
  logic [3:0]    ld_bsel_i;
  logic          ld_ack_o;
  logic          ld_err_o;
  logic [W-1:0]  ld_dat_o;
  logic [W-1:0]  wbm_adr_o;
  logic [W-1:0]  wbm_dat_o;
  logic [3:0]    wbm_sel_o;
  logic          wbm_we_o;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic [W-1:0]  wbm_dat_i;
  logic          wbm_ack_i;
  logic          wbm_err_i;
  logic          store_err_o;
  logic [W-1:0]  store_err_pc_o;
  logic          atomic_done_o;
  logic          idle_o;

  int checks = 0;
  int errors = 0;

  // Slave model configuration (written by the stimulus) and its log (written by the slave).
  int          ack_delay = 0;
  int          err_idx   = -1;
  int          wait_cnt  = 0;
  int          log_n     = 0;
  int          cyc_rise  = 0;
  logic        cyc_prev  = 1'b0;
  logic [31:0] rd_value  = 32'h1234_5678;
  logic [31:0] log_adr [16];
  logic [31:0] log_dat [16];
  logic        log_we  [16];

  pu_or1k_store_drain_ctrl #(
    .OPTION_OPERAND_WIDTH(W),
    .DEPTH_WIDTH         (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .st_req_i      (st_req_i),
    .st_adr_i      (st_adr_i),
    .st_dat_i      (st_dat_i),
    .st_pc_i       (st_pc_i),
    .st_bsel_i     (st_bsel_i),
    .st_atomic_i   (st_atomic_i),
    .st_ack_o      (st_ack_o),
    .ld_req_i      (ld_req_i),
    .ld_adr_i      (ld_adr_i),
    .ld_bsel_i     (ld_bsel_i),
    .ld_ack_o      (ld_ack_o),
    .ld_err_o      (ld_err_o),
    .ld_dat_o      (ld_dat_o),
    .wbm_adr_o     (wbm_adr_o),
    .wbm_dat_o     (wbm_dat_o),
    .wbm_sel_o     (wbm_sel_o),
    .wbm_we_o      (wbm_we_o),
    .wbm_cyc_o     (wbm_cyc_o),
    .wbm_stb_o     (wbm_stb_o),
    .wbm_dat_i     (wbm_dat_i),
    .wbm_ack_i     (wbm_ack_i),
    .wbm_err_i     (wbm_err_i),
    .store_err_o   (store_err_o),
    .store_err_pc_o(store_err_pc_o),
    .atomic_done_o (atomic_done_o),
    .idle_o        (idle_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Slave reacts 1 time unit after each edge; answers after ack_delay wait cycles, one response per bus cycle.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wait_cnt  = 0;
      log_n     = 0;
      cyc_rise  = 0;
      cyc_prev  = 1'b0;
    end else begin
      if (wbm_cyc_o && !cyc_prev) cyc_rise++;
      cyc_prev = wbm_cyc_o;
      if (wbm_ack_i || wbm_err_i) begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wait_cnt  = 0;
      end else if (wbm_cyc_o) begin
        if (wait_cnt == ack_delay) begin
          if (log_n < 16) begin
            log_adr[log_n] = wbm_adr_o;
            log_dat[log_n] = wbm_dat_o;
            log_we[log_n]  = wbm_we_o;
          end
          if (wbm_we_o && log_n == err_idx) wbm_err_i = 1'b1;
          else begin
            wbm_ack_i = 1'b1;
            if (!wbm_we_o) wbm_dat_i = rd_value;
          end
          log_n++;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_store(input logic [31:0] adr, input logic [31:0] dat,
                             input logic [31:0] pc, input logic atomic);
    st_req_i    = 1'b1;
    st_adr_i    = adr;
    st_dat_i    = dat;
    st_pc_i     = pc;
    st_bsel_i   = 4'hF;
    st_atomic_i = atomic;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    st_req_i    = 1'b0;
    st_atomic_i = 1'b0;
    ld_req_i    = 1'b0;
    err_idx     = -1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      step();
      #1;
      if (idle_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_idle: idle_o=%b after %0d cycles, required 1", idle_o, budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({idle_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, store_err_o, atomic_done_o, st_ack_o} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: {idle,cyc,stb,we,serr,adone,stack}=%b required 1000000",
               {idle_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, store_err_o, atomic_done_o, st_ack_o});
    end
    checks++;
    if (store_err_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_err_pc: got %h required 00000000", store_err_pc_o);
    end
  endtask

  task automatic test_single_store();
    do_reset();
    ack_delay = 0;
    step();
    drive_store(32'h100, 32'hDEAD_BEEF, 32'h1000, 1'b0);
    #1;
    checks++;
    if (st_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: st_ack_o=%b required 1", st_ack_o);
    end
    step();
    st_req_i = 1'b0;
    #1;
    checks++;
    if ({wbm_cyc_o, idle_o} !== 2'b00) begin
      errors++;
      $display("FAIL single_cycle1: {cyc,idle}=%b required 00", {wbm_cyc_o, idle_o});
    end
    step();
    #1;
    checks++;
    if (wbm_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL single_cycle2: cyc=%b required 0", wbm_cyc_o);
    end
    step();
    #1;
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b111 || wbm_adr_o !== 32'h100 ||
        wbm_dat_o !== 32'hDEAD_BEEF || wbm_sel_o !== 4'hF) begin
      errors++;
      $display("FAIL single_cycle3: cyc/stb/we=%b adr=%h dat=%h sel=%h required 111 00000100 deadbeef f",
               {wbm_cyc_o, wbm_stb_o, wbm_we_o}, wbm_adr_o, wbm_dat_o, wbm_sel_o);
    end
    step();
    #1;
    checks++;
    if ({wbm_cyc_o, idle_o} !== 2'b01) begin
      errors++;
      $display("FAIL single_after_ack: {cyc,idle}=%b required 01", {wbm_cyc_o, idle_o});
    end
    repeat (3) step();
    #1;
    checks++;
    if (log_n !== 1) begin
      errors++;
      $display("FAIL single_write_count: got %0d required 1", log_n);
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    logic exp_ack;
    do_reset();
    ack_delay = 4;
    // Six stores into a 4-entry buffer: the first drains early, the sixth waits for the second pop.
    for (int c = 0; c < 10; c++) begin
      step();
      drive_store(32'h300 + 32'(idx * 4), 32'hA000_0000 + 32'(idx), 32'h3000 + 32'(idx * 4), 1'b0);
      #1;
      exp_ack = (c <= 4) || (c == 9);
      checks++;
      if (st_ack_o !== exp_ack) begin
        errors++;
        $display("FAIL b2b_ack_c%0d: st_ack_o=%b required %b", c, st_ack_o, exp_ack);
      end
      if (st_ack_o === 1'b1) idx++;
    end
    step();
    st_req_i = 1'b0;
    wait_idle(200);
    checks++;
    if (log_n !== 6) begin
      errors++;
      $display("FAIL b2b_write_count: got %0d required 6", log_n);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (log_adr[k] !== 32'h300 + 32'(k * 4) || log_dat[k] !== 32'hA000_0000 + 32'(k) || log_we[k] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_order_%0d: adr=%h dat=%h we=%b required %h %h 1",
                 k, log_adr[k], log_dat[k], log_we[k], 32'h300 + 32'(k * 4), 32'hA000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_load_after_stores();
    bit got = 1'b0;
    do_reset();
    ack_delay = 1;
    step();
    drive_store(32'h400, 32'h1111_1111, 32'h4000, 1'b0);
    step();
    drive_store(32'h404, 32'h2222_2222, 32'h4004, 1'b0);
    ld_req_i  = 1'b1;
    ld_adr_i  = 32'h200;
    ld_bsel_i = 4'hF;
    #1;
    checks++;
    if (st_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL load_store_priority: st_ack_o=%b required 1", st_ack_o);
    end
    for (int c = 0; c < 100 && !got; c++) begin
      step();
      st_req_i = 1'b0;
      #1;
      if (ld_ack_o === 1'b1) begin
        got = 1'b1;
        checks++;
        if (log_n !== 3 || log_we[0] !== 1'b1 || log_we[1] !== 1'b1 || log_we[2] !== 1'b0 ||
            log_adr[2] !== 32'h200) begin
          errors++;
          $display("FAIL load_order: n=%0d we=%b%b%b adr2=%h required 3 110 00000200",
                   log_n, log_we[0], log_we[1], log_we[2], log_adr[2]);
        end
        checks++;
        if (ld_dat_o !== 32'h1234_5678 || ld_err_o !== 1'b0) begin
          errors++;
          $display("FAIL load_data: dat=%h err=%b required 12345678 0", ld_dat_o, ld_err_o);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL load_timeout: ld_ack_o=%b never seen, required 1", ld_ack_o);
    end
    step();
    ld_req_i = 1'b0;
    wait_idle(50);
  endtask

  task automatic test_atomic();
    int acc = -1;
    int pulses = 0;
    int pulse_c = -1;
    do_reset();
    ack_delay = 2;
    step();
    drive_store(32'h500, 32'hA70A_70A7, 32'h5000, 1'b1);
    #1;
    checks++;
    if (st_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL atomic_accept: st_ack_o=%b required 1", st_ack_o);
    end
    for (int c = 1; c < 10; c++) begin
      step();
      drive_store(32'h504, 32'h5555_5555, 32'h5004, 1'b0);
      if (acc >= 0) st_req_i = 1'b0;
      #1;
      if (atomic_done_o === 1'b1) begin
        pulses++;
        pulse_c = c;
      end
      if (acc < 0 && st_ack_o === 1'b1) acc = c;
    end
    checks++;
    if (acc !== 6) begin
      errors++;
      $display("FAIL atomic_stall: plain store accepted cycle %0d required 6", acc);
    end
    checks++;
    if (pulses !== 1 || pulse_c !== 5) begin
      errors++;
      $display("FAIL atomic_done: pulses=%0d at cycle %0d required 1 at 5", pulses, pulse_c);
    end
    st_req_i = 1'b0;
    wait_idle(50);
    checks++;
    if (log_n !== 2 || log_adr[0] !== 32'h500 || log_adr[1] !== 32'h504) begin
      errors++;
      $display("FAIL atomic_order: n=%0d adr0=%h adr1=%h required 2 00000500 00000504",
               log_n, log_adr[0], log_adr[1]);
    end
  endtask

  task automatic test_store_error();
    int accepted = 0;
    int pulses = 0;
    logic [31:0] pc_seen = '0;
    do_reset();
    ack_delay = 0;
    err_idx   = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      drive_store(32'h600 + 32'(k * 4), 32'hE000_0000 + 32'(k), 32'h2000 + 32'(k * 4), 1'b0);
      #1;
      if (st_ack_o === 1'b1) accepted++;
    end
    checks++;
    if (accepted !== 3) begin
      errors++;
      $display("FAIL err_accept: accepted %0d required 3", accepted);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      st_req_i = 1'b0;
      #1;
      if (store_err_o === 1'b1) begin
        pulses++;
        pc_seen = store_err_pc_o;
      end
    end
    checks++;
    if (pulses !== 1 || pc_seen !== 32'h2004) begin
      errors++;
      $display("FAIL err_pulse: pulses=%0d pc=%h required 1 00002004", pulses, pc_seen);
    end
    checks++;
    if (log_n !== 3 || log_adr[2] !== 32'h608 || log_we[2] !== 1'b1) begin
      errors++;
      $display("FAIL err_continue: n=%0d adr2=%h we2=%b required 3 00000608 1", log_n, log_adr[2], log_we[2]);
    end
    checks++;
    if (store_err_pc_o !== 32'h2004 || idle_o !== 1'b1) begin
      errors++;
      $display("FAIL err_hold: pc=%h idle=%b required 00002004 1", store_err_pc_o, idle_o);
    end
    err_idx = -1;
  endtask

  task automatic test_reset_mid_store();
    int accepted = 0;
    bit cyc_seen = 1'b0;
    do_reset();
    ack_delay = 40;
    for (int k = 0; k < 4; k++) begin
      step();
      drive_store(32'h700 + 32'(k * 4), 32'h7000_0000 + 32'(k), 32'h7000 + 32'(k * 4), 1'b0);
      #1;
      if (st_ack_o === 1'b1) accepted++;
    end
    step();
    st_req_i = 1'b0;
    #1;
    checks++;
    if (accepted !== 4 || wbm_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup: accepted=%0d cyc=%b required 4 1", accepted, wbm_cyc_o);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, idle_o} !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_drop: {cyc,stb,idle}=%b required 001", {wbm_cyc_o, wbm_stb_o, idle_o});
    end
    for (int c = 0; c < 30; c++) begin
      step();
      #1;
      if (wbm_cyc_o !== 1'b0) cyc_seen = 1'b1;
    end
    checks++;
    if (cyc_seen || cyc_rise !== 0) begin
      errors++;
      $display("FAIL rstmid_quiet: bus cycles after reset=%0d required 0", cyc_rise);
    end
    checks++;
    if (idle_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_idle: idle_o=%b required 1", idle_o);
    end
  endtask

  initial begin
    rst         = 1'b1;
    st_req_i    = 1'b0;
    st_adr_i    = '0;
    st_dat_i    = '0;
    st_pc_i     = '0;
    st_bsel_i   = '0;
    st_atomic_i = 1'b0;
    ld_req_i    = 1'b0;
    ld_adr_i    = '0;
    ld_bsel_i   = '0;
    wbm_dat_i   = '0;
    wbm_ack_i   = 1'b0;
    wbm_err_i   = 1'b0;

    test_reset();
    test_single_store();
    test_back_to_back();
    test_load_after_stores();
    test_atomic();
    test_store_error();
    test_reset_mid_store();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
